sga_game_engine: RTL and testbench
==================================

Name: sga_game_engine

Overview:
- Parametrised successor of the Snake Game Arcade top level. Replaces the fixed 6x6, size-counter-only datapath with a complete engine.
- Engine features: configurable board, snake body held in a circular buffer, occupancy bitmap, direction logic with no-reverse rule, move timer, LFSR apple placement, and real border/body/apple detection.
- Drives the LED matrix and win/lose flags directly. The board-level wrapper adds only 7-segment decoding.

Parameters:
- BOARD_W, 6, board columns (2..16)
- BOARD_H, 6, board rows (2..16)
- MAX_LEN, 16, snake length that wins; also circular-buffer depth (2..BOARD_W*BOARD_H)
- TICK_CYCLES, 25000000, clock cycles per snake move (>=2)
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit apple LFSR

Ports:
- clock  in  1  system clock, all logic on its rising edge
- restart  in  1  synchronous active-high reset; returns engine to IDLE
- start  in  1  level; leaves IDLE/WON/LOST and begins a game
- pause  in  1  level; freezes play while high
- buttons  in  4  level; [0]=up [1]=down [2]=left [3]=right
- finished  out  1  high in WON or LOST
- won  out  1  high in WON
- lost  out  1  high in LOST
- db_state  out  4  state encoding
- db_size  out  $clog2(MAX_LEN+1)  current snake length
- db_apples  out  8  apples eaten, saturating at 255
- db_apple_pos  out  8  apple cell index, y*BOARD_W+x
- db_leds  out  BOARD_W*BOARD_H  bitmap of body OR apple; bit index = cell index

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - LFSR=LFSR_SEED.
  - Buffer pointers 0, direction=right.
- States and encodings:
  - IDLE 0
  - INIT 1
  - PLACE 2
  - WAIT 3
  - CALC 4
  - CHECK 5
  - UPDATE 6
  - PAUSED 7
  - WON 8
  - LOST 9
- IDLE --start--> INIT. WON/LOST --start--> INIT. restart from any state --> IDLE on the next edge, even mid-move.
- INIT (1 cycle):
  - Clear bitmap and buffer.
  - Head at cell 0, length 1, db_apples 0, direction right, tick counter 0.
- PLACE:
  - One candidate per cycle: LFSR mod (BOARD_W*BOARD_H).
  - If the candidate cell is free in the bitmap, latch it into db_apple_pos and go to WAIT. Otherwise advance the LFSR and retry.
  - The LFSR advances every cycle in every state.
- WAIT:
  - Tick counter increments. At TICK_CYCLES-1 the counter clears and the state goes to CALC.
  - pause=1 goes to PAUSED; the counter holds.
  - Buttons are sampled every cycle into the pending direction.
  - Multiple buttons pressed: priority up > down > left > right.
  - A request opposite the current direction is ignored.
- PAUSED: pause=0 returns to WAIT with the counter intact.
- CALC (1 cycle):
  - Commit the pending direction.
  - Compute the next head and the border flag (next x or y out of range).
- CHECK (1 cycle), evaluated in this order:
  - Border → LOST.
  - Otherwise body collision = bitmap[next] AND NOT (next==tail AND next!=apple). Moving into the vacating tail is legal. Body collision → LOST.
  - Otherwise go to UPDATE.
- UPDATE (1 cycle):
  - Push the next head and set its bitmap bit.
  - Apple eaten: length+1 and db_apples+1. Then go to WON if length==MAX_LEN, else PLACE.
  - Not eaten: pop the tail and clear its bit, except when the tail equals the new head (bit stays set). Then go to WAIT.
- Latency: the move takes effect 3 cycles after the tick expires.
- Terminal hold: WON/LOST hold the board frozen for display; outputs are registered.

Optional Feature:
- WRAP_BORDER_EN defined:
  - Next-head coordinates wrap modulo the board size.
  - The border flag is forced 0; only body collision can lose.
- Not defined: leaving the board → LOST.

Decomposition:
- Package sga_pkg:
  - State enum and its encodings.
  - Direction enum: UP, DOWN, LEFT, RIGHT.
  - Width functions: CELL_W = $clog2(BOARD_W*BOARD_H), LEN_W.
- Sub-module sga_body_fifo: circular buffer of cell indices with push, pop, head and tail outputs, depth MAX_LEN.
- Bitmap, LFSR and FSM stay in sga_game_engine.

Test Plan (TICK_CYCLES=4, 6x6 unless stated):
- restart, then start pulse → within ≤3+PLACE cycles: db_state=3, db_size=1, db_leds[0]=1, exactly 2 bits set.
- No buttons, apple off row 0 → head steps 1,2,3,4,5 each 4+3 cycles; the 6th move gives lost=1, finished=1, db_state=9. With WRAP_BORDER_EN the head goes to cell 0 instead.
- Moving right, press left for 10 cycles → direction unchanged; then press down → next head cell = head+6.
- Steer toward db_apple_pos → on arrival db_size=2, db_apples=1, a new db_apple_pos differs from every body cell.
- pause=1 for 20 cycles mid-WAIT → db_state=7 and db_leds frozen; after release the move occurs exactly the remaining tick count later.
- MAX_LEN=2, eat one apple → won=1, finished=1, db_state=8. Start → INIT, db_size=1. Restart mid-CHECK → IDLE, all outputs 0.

Source files
------------

// File: rtl/sga_pkg.sv
// rtl/sga_pkg.sv - shared state/direction types and width helpers for the snake engine
package sga_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_PLACE  = 4'd2,
        S_WAIT   = 4'd3,
        S_CALC   = 4'd4,
        S_CHECK  = 4'd5,
        S_UPDATE = 4'd6,
        S_PAUSED = 4'd7,
        S_WON    = 4'd8,
        S_LOST   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Bits needed to index every board cell
    function automatic int cell_width(input int board_w, input int board_h);
        return $clog2(board_w * board_h);
    endfunction

    // Bits needed to hold a length of 0..max_len
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/sga_body_fifo.sv
// rtl/sga_body_fifo.sv - circular buffer of snake body cells, tail at read side, head at write side
module sga_body_fifo #(
    parameter int DEPTH  = 16,
    parameter int CELL_W = 6
) (
    input  logic              clock,
    input  logic              restart,
    input  logic              clear,
    input  logic              push,
    input  logic [CELL_W-1:0] push_cell,
    input  logic              pop,
    output logic [CELL_W-1:0] head,
    output logic [CELL_W-1:0] tail
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CELL_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;

    // Pointer increment that wraps at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Clearing leaves a single entry holding cell 0, which is where a new snake starts
    always_ff @(posedge clock) begin
        if (restart || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                head_ptr           <= bump(head_ptr);
                mem[bump(head_ptr)] <= push_cell;
            end
            if (pop) begin
                tail_ptr <= bump(tail_ptr);
            end
        end
    end

    assign head = mem[head_ptr];
    assign tail = mem[tail_ptr];

endmodule

// File: rtl/sga_game_engine.sv
// rtl/sga_game_engine.sv - snake game engine top; define WRAP_BORDER_EN for wrap-around borders
module sga_game_engine
    import sga_pkg::*;
#(
    parameter int          BOARD_W     = 6,
    parameter int          BOARD_H     = 6,
    parameter int          MAX_LEN     = 16,
    parameter int          TICK_CYCLES = 25000000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                           clock,
    input  logic                           restart,
    input  logic                           start,
    input  logic                           pause,
    input  logic [3:0]                     buttons,
    output logic                           finished,
    output logic                           won,
    output logic                           lost,
    output logic [3:0]                     db_state,
    output logic [$clog2(MAX_LEN+1)-1:0]   db_size,
    output logic [7:0]                     db_apples,
    output logic [7:0]                     db_apple_pos,
    output logic [BOARD_W*BOARD_H-1:0]     db_leds
);

    localparam int CELLS  = BOARD_W * BOARD_H;
    localparam int CELL_W = cell_width(BOARD_W, BOARD_H);
    localparam int LEN_W  = len_width(MAX_LEN);
    localparam int TICK_W = $clog2(TICK_CYCLES);

    state_t              state;
    dir_t                dir;
    dir_t                pend;
    logic [TICK_W-1:0]   tick;
    logic [15:0]         lfsr;
    logic [CELLS-1:0]    bitmap;
    logic [CELL_W-1:0]   apple;
    logic                apple_valid;
    logic [CELL_W-1:0]   next_cell;
    logic                border;
    logic [LEN_W-1:0]    length;
    logic [7:0]          apples;

    logic [CELL_W-1:0]   head;
    logic [CELL_W-1:0]   tail;
    logic [CELL_W-1:0]   cand;
    logic                btn_valid;
    dir_t                btn_dir;
    int                  hx, hy, nx, ny;
    logic [CELL_W-1:0]   calc_cell;
    logic                calc_border;
    logic                hit;
    logic                eaten;

    sga_body_fifo #(
        .DEPTH  (MAX_LEN),
        .CELL_W (CELL_W)
    ) u_body (
        .clock     (clock),
        .restart   (restart),
        .clear     (state == S_INIT),
        .push      (state == S_UPDATE),
        .push_cell (next_cell),
        .pop       ((state == S_UPDATE) && !eaten),
        .head      (head),
        .tail      (tail)
    );

    assign cand  = CELL_W'(32'(lfsr) % 32'(CELLS));
    assign eaten = (next_cell == apple);
    // A cell occupied by the tail is free unless the tail stays put because the apple is eaten
    assign hit   = bitmap[next_cell] && !((next_cell == tail) && (next_cell != apple));

    // Free-running apple LFSR, x^16 + x^14 + x^13 + x^11
    always_ff @(posedge clock) begin
        if (restart) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Button priority: up > down > left > right
    always_comb begin
        btn_valid = 1'b1;
        btn_dir   = DIR_UP;
        if (buttons[0])      btn_dir = DIR_UP;
        else if (buttons[1]) btn_dir = DIR_DOWN;
        else if (buttons[2]) btn_dir = DIR_LEFT;
        else if (buttons[3]) btn_dir = DIR_RIGHT;
        else                 btn_valid = 1'b0;
    end

    // Next head position from the current head and the direction about to be committed
    always_comb begin
        hx = int'(head) % BOARD_W;
        hy = int'(head) / BOARD_W;
        nx = hx;
        ny = hy;
        case (pend)
            DIR_UP:   ny = hy - 1;
            DIR_DOWN: ny = hy + 1;
            DIR_LEFT: nx = hx - 1;
            default:  nx = hx + 1;
        endcase
`ifdef WRAP_BORDER_EN
        nx          = (nx + BOARD_W) % BOARD_W;
        ny          = (ny + BOARD_H) % BOARD_H;
        calc_border = 1'b0;
`else
        calc_border = (nx < 0) || (nx >= BOARD_W) || (ny < 0) || (ny >= BOARD_H);
`endif
        calc_cell = calc_border ? '0 : CELL_W'(ny * BOARD_W + nx);
    end

    // Game FSM with its datapath registers and registered status flags
    always_ff @(posedge clock) begin
        if (restart) begin
            state       <= S_IDLE;
            dir         <= DIR_RIGHT;
            pend        <= DIR_RIGHT;
            tick        <= '0;
            bitmap      <= '0;
            apple       <= '0;
            apple_valid <= 1'b0;
            next_cell   <= '0;
            border      <= 1'b0;
            length      <= '0;
            apples      <= '0;
            won         <= 1'b0;
            lost        <= 1'b0;
            finished    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_INIT;
                end
                S_INIT: begin
                    bitmap      <= CELLS'(1);
                    apple_valid <= 1'b0;
                    length      <= LEN_W'(1);
                    apples      <= '0;
                    dir         <= DIR_RIGHT;
                    pend        <= DIR_RIGHT;
                    tick        <= '0;
                    state       <= S_PLACE;
                end
                S_PLACE: begin
                    if (!bitmap[cand]) begin
                        apple       <= cand;
                        apple_valid <= 1'b1;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (btn_valid && (btn_dir != opposite(dir))) pend <= btn_dir;
                    if (pause) begin
                        state <= S_PAUSED;
                    end else if (tick == TICK_W'(TICK_CYCLES - 1)) begin
                        tick  <= '0;
                        state <= S_CALC;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                S_PAUSED: begin
                    if (!pause) state <= S_WAIT;
                end
                S_CALC: begin
                    dir       <= pend;
                    next_cell <= calc_cell;
                    border    <= calc_border;
                    state     <= S_CHECK;
                end
                S_CHECK: begin
                    if (border || hit) begin
                        state    <= S_LOST;
                        lost     <= 1'b1;
                        finished <= 1'b1;
                    end else begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!eaten) bitmap[tail] <= 1'b0;
                    bitmap[next_cell] <= 1'b1;
                    if (eaten) begin
                        length <= length + LEN_W'(1);
                        apples <= (apples == 8'hFF) ? apples : apples + 8'd1;
                        if (length == LEN_W'(MAX_LEN - 1)) begin
                            state    <= S_WON;
                            won      <= 1'b1;
                            finished <= 1'b1;
                        end else begin
                            state <= S_PLACE;
                        end
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WON, S_LOST: begin
                    if (start) begin
                        state    <= S_INIT;
                        won      <= 1'b0;
                        lost     <= 1'b0;
                        finished <= 1'b0;
                        length   <= LEN_W'(1);
                        apples   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign db_state     = state;
    assign db_size      = length;
    assign db_apples    = apples;
    assign db_apple_pos = 8'(apple);
    assign db_leds      = bitmap | (apple_valid ? (CELLS'(1) << apple) : '0);

endmodule

// File: tb/tb_sga_game_engine.sv
// tb/tb_sga_game_engine.sv - randomized bench for sga_game_engine against a queue-based snake model
module tb_sga_game_engine;

    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

    logic        clock = 1'b0;
    logic        restart, start, pause;
    logic [3:0]  buttons;

    logic        finished, won, lost;
    logic [3:0]  db_state;
    logic [4:0]  db_size;
    logic [7:0]  db_apples, db_apple_pos;
    logic [35:0] db_leds;

    logic        w_finished, w_won, w_lost;
    logic [3:0]  w_db_state;
    logic [1:0]  w_db_size;
    logic [7:0]  w_db_apples, w_db_apple_pos;
    logic [35:0] w_db_leds;

    int n_vec = 0;
    int n_bad = 0;

    int body[$];
    int mdir;
    int mapples;
    int apple;
    bit w_sync;
    bit over;

    sga_game_engine #(.BOARD_W(6), .BOARD_H(6), .MAX_LEN(16), .TICK_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
        .clock(clock), .restart(restart), .start(start), .pause(pause), .buttons(buttons),
        .finished(finished), .won(won), .lost(lost), .db_state(db_state), .db_size(db_size),
        .db_apples(db_apples), .db_apple_pos(db_apple_pos), .db_leds(db_leds)
    );

    sga_game_engine #(.BOARD_W(6), .BOARD_H(6), .MAX_LEN(2), .TICK_CYCLES(4), .LFSR_SEED(16'hACE1)) dut_w (
        .clock(clock), .restart(restart), .start(start), .pause(pause), .buttons(buttons),
        .finished(w_finished), .won(w_won), .lost(w_lost), .db_state(w_db_state), .db_size(w_db_size),
        .db_apples(w_db_apples), .db_apple_pos(w_db_apple_pos), .db_leds(w_db_leds)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] model_leds();
        logic [35:0] m;
        m = '0;
        foreach (body[i]) m[body[i]] = 1'b1;
        m[apple] = 1'b1;
        return m;
    endfunction

    function automatic bit in_body(input int c);
        foreach (body[i]) if (body[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Button pattern that heads toward the apple without requesting a reversal
    function automatic logic [3:0] steer();
        int hx, hy, ax, ay;
        int c[$];
        hx = body[$] % 6; hy = body[$] / 6;
        ax = apple % 6;   ay = apple / 6;
        if (ax > hx) c.push_back(RIGHT); else if (ax < hx) c.push_back(LEFT);
        if (ay > hy) c.push_back(DOWN);  else if (ay < hy) c.push_back(UP);
        foreach (c[i]) if (c[i] != (mdir ^ 1)) return 4'(1 << c[i]);
        if (mdir == LEFT || mdir == RIGHT) return (hy > 0) ? 4'b0001 : 4'b0010;
        return (hx > 0) ? 4'b0100 : 4'b1000;
    endfunction

    task automatic wait_state(input logic [3:0] s, input int bound, input string tag);
        int k;
        k = 0;
        while (db_state !== s && k < bound) begin
            @(negedge clock);
            k++;
        end
        check(tag, db_state, s);
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        w_sync = (w_db_state == 4'd1) && (db_state == 4'd1);
        body.delete();
        body.push_back(0);
        mdir = RIGHT;
        mapples = 0;
        check("init_state", db_state, 4'd1);
        wait_state(4'd3, 300, "start_to_wait");
        apple = db_apple_pos;
        check("start_size", db_size, 1);
        check("start_led0", db_leds[0], 1'b1);
        check("start_popcount", $countones(db_leds), 2);
        check("start_leds", db_leds, model_leds());
        check("start_apple_free", in_body(apple), 0);
    endtask

    task automatic do_move(input logic [3:0] b, input bit with_pause, output bit game_over);
        int req, hx, hy, nx, ny, n, k;
        bit border, die, ate;
        logic [3:0] exp_state, exp_w;
        buttons = b;
        if (with_pause) begin
            @(negedge clock);
            pause = 1'b1;
            repeat (20) @(negedge clock);
            check("paused_state", db_state, 4'd7);
            check("paused_leds", db_leds, model_leds());
            pause = 1'b0;
            buttons = 4'd0;
            k = 0;
            while (db_state !== 4'd4 && k < 50) begin
                @(negedge clock);
                k++;
            end
            check("resume_latency", k, 4);
        end else begin
            repeat (2) @(negedge clock);
            buttons = 4'd0;
            k = 0;
            while (db_state !== 4'd4 && k < 50) begin
                @(negedge clock);
                k++;
            end
            check("calc_reached", db_state, 4'd4);
        end
        repeat (3) @(negedge clock);

        req = b[0] ? UP : b[1] ? DOWN : b[2] ? LEFT : b[3] ? RIGHT : -1;
        if (req >= 0 && req != (mdir ^ 1)) mdir = req;
        hx = body[$] % 6; hy = body[$] / 6;
        nx = hx; ny = hy;
        case (mdir)
            UP:      ny = hy - 1;
            DOWN:    ny = hy + 1;
            LEFT:    nx = hx - 1;
            default: nx = hx + 1;
        endcase
`ifdef WRAP_BORDER_EN
        nx = (nx + 6) % 6;
        ny = (ny + 6) % 6;
        border = 1'b0;
`else
        border = (nx < 0) || (nx > 5) || (ny < 0) || (ny > 5);
`endif
        die = border;
        ate = 1'b0;
        if (!border) begin
            n = ny * 6 + nx;
            if (in_body(n) && !(n == body[0] && n != apple)) begin
                die = 1'b1;
            end else begin
                body.push_back(n);
                if (n == apple) begin
                    ate = 1'b1;
                    if (mapples < 255) mapples++;
                end else begin
                    void'(body.pop_front());
                end
            end
        end

        exp_state = die ? 4'd9 : (ate && body.size() == 16) ? 4'd8 : ate ? 4'd2 : 4'd3;
        check("move_state", db_state, exp_state);
        check("move_size", db_size, body.size());
        check("move_apples", db_apples, mapples);
        check("move_leds", db_leds, model_leds());
        check("move_lost", lost, die);
        check("move_finished", finished, (exp_state == 4'd8) || die);

        if (w_sync) begin
            exp_w = die ? 4'd9 : (ate && body.size() == 2) ? 4'd8 : exp_state;
            check("w_state", w_db_state, exp_w);
            check("w_won", w_won, exp_w == 4'd8);
            check("w_finished", w_finished, (exp_w == 4'd8) || die);
            if (exp_w == 4'd8) begin
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                check("w_restart_state", w_db_state, 4'd1);
                check("w_restart_size", w_db_size, 2'd1);
                check("w_restart_won", w_won, 1'b0);
                w_sync = 1'b0;
            end
        end

        if (ate && !die && exp_state != 4'd8) begin
            wait_state(4'd3, 300, "replace_wait");
            apple = db_apple_pos;
            check("apple_free", in_body(apple), 0);
            check("replace_leds", db_leds, model_leds());
        end
        game_over = die || (exp_state == 4'd8);
    endtask

    task automatic step(input logic [3:0] b);
        do_move(b, 1'b0, over);
        if (over) start_game();
    endtask

    initial begin
        restart = 1'b1; start = 1'b0; pause = 1'b0; buttons = 4'd0;
        w_sync = 1'b0; over = 1'b0;
        repeat (3) @(negedge clock);
        restart = 1'b0;
        @(negedge clock);
        check("rst_state", db_state, 4'd0);
        check("rst_size", db_size, 0);
        check("rst_apples", db_apples, 0);
        check("rst_apple_pos", db_apple_pos, 0);
        check("rst_leds", db_leds, 0);
        check("rst_flags", {finished, won, lost}, 3'b000);
        check("rst_w_outputs", {w_db_state, w_db_size, w_db_apples, w_db_apple_pos, w_finished, w_won, w_lost}, 0);
        check("rst_w_leds", w_db_leds, 0);

        start_game();

        // Straight run with no buttons, first move interrupted by a pause
        do_move(4'd0, 1'b1, over);
        for (int i = 0; i < 8 && !over; i++) do_move(4'd0, 1'b0, over);
        if (over) start_game();

        // Reversal request is ignored, a perpendicular turn is taken
        step(4'b0100);
        step(4'b0100);
        step(4'b0010);

        // Chase apples
        for (int i = 0; i < 40 && mapples == 0; i++) step(steer());
        for (int i = 0; i < 20; i++) step(steer());

        // Random play
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) step(steer());
            else step(4'($urandom_range(0, 15)));
        end

        // Restart in the middle of a move
        wait_state(4'd4, 50, "pre_restart_calc");
        @(negedge clock);
        check("mid_check_state", db_state, 4'd5);
        restart = 1'b1;
        @(negedge clock);
        check("restart_state", db_state, 4'd0);
        check("restart_outputs", {db_size, db_apples, db_apple_pos, finished, won, lost}, 0);
        check("restart_leds", db_leds, 0);
        check("restart_w_state", w_db_state, 4'd0);
        check("restart_w_leds", w_db_leds, 0);
        restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
